// File: rtl/control_unit.sv
// control_unit: multi-cycle sequencer that fetches 16-bit instructions from
// inst_reg, reads operands from the register file, drives the ALU and writes
// results back, running from pc=0 to the last address or until HALT.
module control_unit #(
  parameter int unsigned PC_W   = 2,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [PC_W-1:0]   pc,
  output logic              ir_en,
  input  logic [15:0]       ir_data,
  output logic [1:0]        reg_addr,
  output logic              reg_rd,
  output logic              reg_wr,
  output logic [DATA_W-1:0] reg_wdata,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic [2:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_out,
  output logic              busy,
  output logic              done
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_READ_A,
    S_READ_B,
    S_EXEC,
    S_WRITE,
    S_NEXT,
    S_DONE
  } state_t;

  localparam logic [3:0]      CLS_ADD  = 4'b0000;
  localparam logic [3:0]      CLS_SUB  = 4'b0001;
  localparam logic [3:0]      CLS_LOAD = 4'b1000;
  localparam logic [3:0]      CLS_HALT = 4'b1111;
  localparam logic [PC_W-1:0] PC_LAST  = '1;

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [15:0]         ir_q, ir_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [2:0]          op_q, op_d;

  logic [3:0]          ir_cls;
  logic                unused_ir;

  assign ir_cls    = ir_q[15:12];
  // Bits [11:10] are reserved in every instruction format.
  assign unused_ir = ^ir_q[11:10];

  assign pc     = pc_q;
  assign alu_op = op_q;
  assign alu_a  = a_q;
  assign alu_b  = b_q;

  // State and datapath registers; async reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      res_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      res_q   <= res_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
    end
  end

  // Next-state and register-update logic; everything holds by default.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    res_d   = res_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        ir_d    = ir_data;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        unique case (ir_cls)
          CLS_ADD: begin
            op_d    = 3'b000;
            state_d = S_READ_A;
          end
          CLS_SUB: begin
            op_d    = 3'b001;
            state_d = S_READ_A;
          end
          CLS_LOAD: state_d = S_WRITE;
          CLS_HALT: state_d = S_DONE;
          default:  state_d = S_NEXT;
        endcase
      end
      S_READ_A: begin
        a_d     = reg_rdata;
        state_d = S_READ_B;
      end
      S_READ_B: begin
        b_d     = reg_rdata;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        res_d   = alu_out;
        state_d = S_WRITE;
      end
      S_WRITE: state_d = S_NEXT;
      S_NEXT: begin
        if (pc_q == PC_LAST) begin
          state_d = S_DONE;
        end else begin
          pc_d    = pc_q + PC_W'(1);
          state_d = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes and addresses decoded from state so reset removes them at once.
  always_comb begin
    ir_en     = 1'b0;
    reg_addr  = '0;
    reg_rd    = 1'b0;
    reg_wr    = 1'b0;
    reg_wdata = '0;
    busy      = (state_q != S_IDLE);
    done      = 1'b0;
    unique case (state_q)
      S_FETCH: ir_en = 1'b1;
      S_READ_A: begin
        reg_addr = ir_q[5:4];
        reg_rd   = 1'b1;
      end
      S_READ_B: begin
        reg_addr = ir_q[1:0];
        reg_rd   = 1'b1;
      end
      S_WRITE: begin
        reg_addr  = ir_q[9:8];
        reg_wr    = 1'b1;
        reg_wdata = (ir_cls == CLS_LOAD) ? DATA_W'(ir_q[7:0]) : res_q;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: drives control_unit with a behavioural ROM, register file
// and ALU, and checks results against an instruction-level program model.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  pc;
  logic        ir_en;
  logic [15:0] ir_data;
  logic [1:0]  reg_addr;
  logic        reg_rd;
  logic        reg_wr;
  logic [7:0]  reg_wdata;
  logic [7:0]  reg_rdata;
  logic [2:0]  alu_op;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [7:0]  alu_out;
  logic        busy;
  logic        done;

  logic [15:0] rom  [4];
  logic [7:0]  regs [4];

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [15:0] HALT = 16'hF000;

  always #5 clk = ~clk;

  control_unit #(.PC_W(2), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pc(pc), .ir_en(ir_en),
    .ir_data(ir_data), .reg_addr(reg_addr), .reg_rd(reg_rd), .reg_wr(reg_wr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .alu_op(alu_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out), .busy(busy), .done(done)
  );

  assign ir_data   = ir_en ? rom[pc] : 16'h0000;
  assign reg_rdata = reg_rd ? regs[reg_addr] : 8'h00;
  assign alu_out   = (alu_op == 3'b001) ? 8'(alu_a - alu_b) : 8'(alu_a + alu_b);

  always @(posedge clk) if (reg_wr) regs[reg_addr] <= reg_wdata;

  function automatic logic [15:0] i_load(input int d, input int imm);
    return {4'h8, 2'b00, 2'(d), 8'(imm)};
  endfunction
  function automatic logic [15:0] i_alu(input logic [3:0] c, input int d, input int a, input int b);
    return {c, 2'b00, 2'(d), 2'b00, 2'(a), 2'b00, 2'(b)};
  endfunction

  // Instruction-level model: per-instruction semantics and cycle costs.
  function automatic void ref_run(input logic [15:0] p [4], input logic [7:0] ri [4],
                                  output logic [7:0] ro [4], output int dc,
                                  output int last, output int nw);
    int cyc = 0;
    ro = ri; nw = 0; last = 3;
    for (int k = 0; k < 4; k++) begin
      logic [3:0] c = p[k][15:12];
      int d = int'(p[k][9:8]);
      int a = int'(p[k][5:4]);
      int b = int'(p[k][1:0]);
      if (c == 4'hF) begin cyc += 2; last = k; break; end
      else if (c == 4'h0) begin ro[d] = 8'((int'(ro[a]) + int'(ro[b])) % 256); cyc += 7; nw++; end
      else if (c == 4'h1) begin ro[d] = 8'((int'(ro[a]) - int'(ro[b]) + 256) % 256); cyc += 7; nw++; end
      else if (c == 4'h8) begin ro[d] = p[k][7:0]; cyc += 4; nw++; end
      else cyc += 3;
    end
    dc = 1 + cyc;
  endfunction

  // Starts a program and observes it until done (bounded); pulse_at re-asserts
  // start in that cycle to probe that start is ignored while busy.
  task automatic run_prog(input int pulse_at, output int done_cyc, output int wr_cnt,
                          output int rd_cnt, output int overlap, output logic [1:0] pc_fin,
                          output logic [1:0] pc4, output logic [7:0] wa, output logic [7:0] wb,
                          output logic busy_after, output logic done_after);
    int cyc = 0;
    done_cyc = -1; wr_cnt = 0; rd_cnt = 0; overlap = 0;
    pc_fin = '0; pc4 = '0; wa = '0; wb = '0;
    @(negedge clk); start = 1'b1;
    while (done_cyc < 0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      start = (cyc == pulse_at);
      if (reg_wr) begin wr_cnt++; wa = alu_a; wb = alu_b; end
      if (reg_rd) rd_cnt++;
      if (reg_rd && reg_wr) overlap++;
      if (cyc == 4) pc4 = pc;
      if (done) begin done_cyc = cyc; pc_fin = pc; end
    end
    start = 1'b0;
    @(negedge clk);
    busy_after = busy; done_after = done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0;
    for (int i = 0; i < 4; i++) begin rom[i] = HALT; regs[i] = '0; end
    #1;
    n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done: got %b%b expected 00", busy, done); end
    n_tests++; if (pc !== 2'd0 || alu_op !== 3'd0) begin n_fail++; $display("FAIL reset_pc_op: got pc=%0d op=%0d expected 0 0", pc, alu_op); end
    n_tests++; if ({alu_a, alu_b, reg_wdata} !== 24'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 000000", {alu_a, alu_b, reg_wdata}); end
    n_tests++; if ({reg_wr, reg_rd, ir_en, reg_addr} !== 5'b0) begin n_fail++; $display("FAIL reset_strobes: got %b expected 00000", {reg_wr, reg_rd, ir_en, reg_addr}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_program(input int pulse_at);
    int dc, nw, nr, ov; logic [1:0] pf, p4; logic [7:0] wa, wb; logic ba, da;
    rom[0] = i_load(0, 5); rom[1] = i_load(1, 7);
    rom[2] = i_alu(4'h0, 2, 0, 1); rom[3] = i_alu(4'h1, 3, 0, 1);
    for (int i = 0; i < 4; i++) regs[i] = '0;
    run_prog(pulse_at, dc, nw, nr, ov, pf, p4, wa, wb, ba, da);
    n_tests++; if ({regs[0], regs[1], regs[2], regs[3]} !== {8'd5, 8'd7, 8'd12, 8'd254}) begin n_fail++; $display("FAIL prog_regs: got %0d %0d %0d %0d expected 5 7 12 254", regs[0], regs[1], regs[2], regs[3]); end
    n_tests++; if (dc != 23) begin n_fail++; $display("FAIL prog_done_cycle: got %0d expected 23", dc); end
    n_tests++; if (ba !== 1'b0 || da !== 1'b0) begin n_fail++; $display("FAIL prog_after_done: got busy=%b done=%b expected 0 0", ba, da); end
    n_tests++; if (pf !== 2'd3) begin n_fail++; $display("FAIL prog_pc: got %0d expected 3", pf); end
    n_tests++; if (nw != 4 || ov != 0) begin n_fail++; $display("FAIL prog_strobes: got wr=%0d overlap=%0d expected 4 0", nw, ov); end
  endtask

  task automatic test_halt();
    int dc, nw, nr, ov; logic [1:0] pf, p4; logic [7:0] wa, wb; logic ba, da;
    rom[0] = i_load(0, 9); rom[1] = HALT; rom[2] = i_load(1, 1); rom[3] = i_load(2, 2);
    regs[0] = 8'h00; regs[1] = 8'h11; regs[2] = 8'h22; regs[3] = 8'h33;
    run_prog(0, dc, nw, nr, ov, pf, p4, wa, wb, ba, da);
    n_tests++; if (dc != 7) begin n_fail++; $display("FAIL halt_done_cycle: got %0d expected 7", dc); end
    n_tests++; if (pf !== 2'd1) begin n_fail++; $display("FAIL halt_pc: got %0d expected 1", pf); end
    n_tests++; if ({regs[0], regs[1], regs[2]} !== {8'd9, 8'h11, 8'h22}) begin n_fail++; $display("FAIL halt_regs: got %h %h %h expected 09 11 22", regs[0], regs[1], regs[2]); end
    n_tests++; if (nw != 1) begin n_fail++; $display("FAIL halt_wr_count: got %0d expected 1", nw); end
  endtask

  task automatic test_nop();
    int dc, nw, nr, ov; logic [1:0] pf, p4; logic [7:0] wa, wb; logic ba, da;
    rom[0] = 16'h4123; rom[1] = HALT; rom[2] = HALT; rom[3] = HALT;
    run_prog(0, dc, nw, nr, ov, pf, p4, wa, wb, ba, da);
    n_tests++; if (nr != 0 || nw != 0) begin n_fail++; $display("FAIL nop_strobes: got rd=%0d wr=%0d expected 0 0", nr, nw); end
    n_tests++; if (p4 !== 2'd1) begin n_fail++; $display("FAIL nop_pc_cycle4: got %0d expected 1", p4); end
    n_tests++; if (dc != 6) begin n_fail++; $display("FAIL nop_done_cycle: got %0d expected 6", dc); end
  endtask

  task automatic test_alias();
    int dc, nw, nr, ov; logic [1:0] pf, p4; logic [7:0] wa, wb; logic ba, da;
    rom[0] = i_alu(4'h0, 1, 1, 1); rom[1] = HALT;
    regs[1] = 8'd200;
    run_prog(0, dc, nw, nr, ov, pf, p4, wa, wb, ba, da);
    n_tests++; if (regs[1] !== 8'd144) begin n_fail++; $display("FAIL alias_result: got %0d expected 144", regs[1]); end
    n_tests++; if (wa !== 8'd200 || wb !== 8'd200) begin n_fail++; $display("FAIL alias_operands: got %0d %0d expected 200 200", wa, wb); end
    n_tests++; if (dc != 10 || nr != 2) begin n_fail++; $display("FAIL alias_timing: got done=%0d rd=%0d expected 10 2", dc, nr); end
  endtask

  task automatic test_reset_mid();
    int w = 0, c = 0;
    rom[0] = i_load(0, 5); rom[1] = i_load(1, 7);
    rom[2] = i_alu(4'h0, 2, 0, 1); rom[3] = i_alu(4'h1, 3, 0, 1);
    regs[0] = '0; regs[1] = '0; regs[2] = 8'hAA; regs[3] = '0;
    @(negedge clk); start = 1'b1;
    while (w < 3 && c < 100) begin
      @(negedge clk); c++; start = 1'b0;
      if (reg_wr) w++;
    end
    n_tests++; if (w != 3) begin n_fail++; $display("FAIL midrst_reach_write: got %0d writes expected 3", w); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (reg_wr !== 1'b0) begin n_fail++; $display("FAIL midrst_wr_drop: got %b expected 0", reg_wr); end
    n_tests++; if (busy !== 1'b0 || pc !== 2'd0) begin n_fail++; $display("FAIL midrst_state: got busy=%b pc=%0d expected 0 0", busy, pc); end
    @(posedge clk); #1;
    n_tests++; if (regs[2] !== 8'hAA) begin n_fail++; $display("FAIL midrst_dest: got %h expected aa", regs[2]); end
    @(negedge clk); rst_n = 1'b1;
    test_program(6);
  endtask

  task automatic test_back_to_back();
    logic [9:0] dmask = '0; logic b4 = 1'b1; logic [1:0] p5 = 2'd3; logic bz5 = 1'b0;
    rom[0] = HALT;
    @(negedge clk); start = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (done) dmask[c] = 1'b1;
      if (c == 4) b4 = busy;
      if (c == 5) begin p5 = pc; bz5 = busy; start = 1'b0; end
    end
    n_tests++; if (dmask !== 10'h088) begin n_fail++; $display("FAIL b2b_done_cycles: got %b expected 0010001000", dmask); end
    n_tests++; if (b4 !== 1'b0 || bz5 !== 1'b1 || p5 !== 2'd0) begin n_fail++; $display("FAIL b2b_restart: got idle_busy=%b busy=%b pc=%0d expected 0 1 0", b4, bz5, p5); end
  endtask

  task automatic test_random(input int iters);
    int dc, nw, nr, ov; logic [1:0] pf, p4; logic [7:0] wa, wb; logic ba, da;
    logic [7:0] r0 [4]; logic [7:0] re [4]; int edc, elast, enw;
    for (int it = 0; it < iters; it++) begin
      for (int k = 0; k < 4; k++) begin
        int sel = $urandom_range(0, 9);
        logic [15:0] ins = 16'($urandom);
        logic [3:0] nop;
        do nop = 4'($urandom); while (nop == 4'h0 || nop == 4'h1 || nop == 4'h8 || nop == 4'hF);
        if (sel < 3)      ins[15:12] = 4'h0;
        else if (sel < 5) ins[15:12] = 4'h1;
        else if (sel < 8) ins[15:12] = 4'h8;
        else if (sel < 9) ins[15:12] = nop;
        else              ins[15:12] = 4'hF;
        rom[k] = ins;
        regs[k] = 8'($urandom);
        r0[k] = regs[k];
      end
      ref_run(rom, r0, re, edc, elast, enw);
      run_prog(0, dc, nw, nr, ov, pf, p4, wa, wb, ba, da);
      n_tests++; if ({regs[0], regs[1], regs[2], regs[3]} !== {re[0], re[1], re[2], re[3]}) begin n_fail++; $display("FAIL rand%0d_regs: got %h %h %h %h expected %h %h %h %h", it, regs[0], regs[1], regs[2], regs[3], re[0], re[1], re[2], re[3]); end
      n_tests++; if (dc != edc || int'(pf) != elast) begin n_fail++; $display("FAIL rand%0d_timing: got done=%0d pc=%0d expected %0d %0d", it, dc, pf, edc, elast); end
      n_tests++; if (nw != enw || ov != 0 || ba !== 1'b0) begin n_fail++; $display("FAIL rand%0d_strobes: got wr=%0d overlap=%0d busy=%b expected %0d 0 0", it, nw, ov, ba, enw); end
    end
  endtask

  initial begin
    test_reset();
    test_program(0);
    test_halt();
    test_nop();
    test_alias();
    test_reset_mid();
    test_back_to_back();
    test_random(25);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multi-cycle sequencer for the 8-bit processor. It replaces the hand-driven stimulus currently used to exercise the datapath.
- Sequence per instruction: drive pc/en into inst_reg, latch the 16-bit instruction, decode it, read operands from registers, drive alu, write the result back.
- Runs the program from pc=0 to the last address, or until a HALT instruction, then pulses done.

Parameters:
- PC_W, 2, program counter width; last instruction address = 2**PC_W-1.
- DATA_W, 8, register/ALU data width.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin program execution; sampled only in IDLE.
- pc  output  PC_W  instruction address to inst_reg.
- ir_en  output  1  inst_reg enable.
- ir_data  input  16  instruction from inst_reg; combinational from pc/ir_en.
- reg_addr  output  2  register file address.
- reg_rd  output  1  register read strobe.
- reg_wr  output  1  register write strobe.
- reg_wdata  output  DATA_W  register write data.
- reg_rdata  input  DATA_W  register read data; combinational from reg_addr/reg_rd.
- alu_op  output  3  ALU opcode: 000 add, 001 sub.
- alu_a  output  DATA_W  ALU operand A (registered).
- alu_b  output  DATA_W  ALU operand B (registered).
- alu_out  input  DATA_W  ALU result; combinational.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at program end.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0, including pc, alu_op, alu_a, alu_b, reg_wdata, reg_wr, done. Internal IR and result registers cleared. Takes effect immediately, including mid-instruction: reg_wr drops without waiting for a clock edge.
- Instruction format:
  - [15:12] class: 0000 ADD, 0001 SUB, 1000 LOAD, 1111 HALT, all others NOP.
  - [9:8] destination register.
  - [5:4] source A; [1:0] source B.
  - [7:0] LOAD immediate.
- FSM; one cycle per state; outputs are registered or decoded from state:
  - IDLE: busy=0. If start=1, go to FETCH with pc=0. Otherwise stay.
  - FETCH: ir_en=1. Latch ir_data into IR at the end of the cycle. Go to DECODE.
  - DECODE: ir_en=0. For ADD/SUB, load alu_op (ADD→000, SUB→001) and go to READ_A. LOAD→WRITE. HALT→DONE. NOP→NEXT.
  - READ_A: reg_addr=IR[5:4], reg_rd=1. Capture reg_rdata into alu_a. Go to READ_B.
  - READ_B: reg_addr=IR[1:0], reg_rd=1. Capture reg_rdata into alu_b. Go to EXEC.
  - EXEC: reg_rd=0. Capture alu_out into the result register. Go to WRITE.
  - WRITE: reg_addr=IR[9:8], reg_wr=1. reg_wdata = IR[7:0] for LOAD, result for ADD/SUB. Go to NEXT.
  - NEXT: reg_wr=0. If pc == 2**PC_W-1, go to DONE (pc unchanged). Else pc=pc+1 and go to FETCH.
  - DONE: done=1 for exactly one cycle, busy=1. Go to IDLE. pc holds its final value until the next start.
- Instruction latency: LOAD 4 cycles; ADD/SUB 7 cycles; NOP 3 cycles; HALT 2 cycles to DONE.
- Strobes: reg_rd and reg_wr are never high in the same cycle. reg_wr is high for exactly one cycle per LOAD/ADD/SUB and never for NOP/HALT.
- Hold rules:
  - alu_op holds its value between DECODEs.
  - alu_a and alu_b hold between their captures.
  - reg_addr returns to 0 in states that do not drive it.
- Arithmetic: modulo 2**DATA_W, performed by the ALU. The control unit does no width extension.
- Operand aliasing: when source A, source B and destination are the same register, A and B are both read before the write. Example: ADD R1,R1,R1 doubles R1.
- start while busy=1 is ignored. start held high through DONE causes a restart from the following IDLE cycle.

Test Plan:
1. Bench instantiates control_unit with the team alu and registers and a behavioural 4-entry ROM. Cycle 0 is the IDLE cycle in which start is sampled high.
2. Program LOAD R0,5; LOAD R1,7; ADD R2,R0,R1; SUB R3,R0,R1 → R0=5, R1=7, R2=12, R3=254. done is high in cycle 23 only; busy is low from cycle 24; pc=3.
3. Program LOAD R0,9; HALT; LOAD R1,1; LOAD R2,2 → done in cycle 7, pc=1, R1 and R2 unchanged. Exactly one reg_wr pulse.
4. Opcode 0100 at pc=0 → FETCH, DECODE, NEXT with no reg_rd/reg_wr pulses. pc=1 in cycle 4.
5. ADD R1,R1,R1 with R1=200 → R1=144 (wraps modulo 256). alu_a=alu_b=200 captured before the write.
6. Drop rst_n during the WRITE cycle of an ADD → reg_wr falls immediately and the destination register is unchanged. After reset: busy=0 and pc=0. A pulse on start mid-run is ignored; a new start after reset reruns from pc=0 with correct results.
